// File: rtl/painterengine_gpu_dma_reader_pkg.sv
// Shared encodings and AXI constants for the GPU DMA reader and writer.
// No logic lives here, only types, codes and fixed field values.
package painterengine_gpu_dma_reader_pkg;

  typedef enum logic [2:0] {
    ST_ROUTING,
    ST_PARAM_CHECK,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } dma_state_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_ROUTING    = 3'd1,
    ERR_ALIGN      = 3'd2,
    ERR_LENGTH     = 3'd3,
    ERR_AR_TIMEOUT = 3'd4,
    ERR_RRESP      = 3'd5,
    ERR_RLAST      = 3'd6,
    ERR_R_TIMEOUT  = 3'd7
  } dma_err_e;

  localparam int         DEFAULT_TIMEOUT = 256;
  localparam int         BOUNDARY_BEATS  = 256;   // 1 KB of 32-bit words
  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD   = 4'b0010;

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// Combinational burst sizing: next burst address and beat count (1..256),
// clipped so a burst never crosses a 1 KB boundary or runs past the length.
module painterengine_gpu_burst_calc
  import painterengine_gpu_dma_reader_pkg::*;
(
  input  logic [31:0] i_address,
  input  logic [31:0] i_offset,
  input  logic [31:0] i_length,
  output logic [31:0] o_burst_addr,
  output logic [8:0]  o_beats
);

  logic [8:0]  room;
  logic [31:0] remaining;

  always_comb begin
    o_burst_addr = i_address + {i_offset[29:0], 2'b00};
    room         = 9'(BOUNDARY_BEATS) - {1'b0, o_burst_addr[9:2]};
    remaining    = i_length - i_offset;
    o_beats      = (remaining < {23'd0, room}) ? remaining[8:0] : room;
  end

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master feeding one of four GPU lanes; R data passes through with zero latency.
// Backpressure: RREADY follows the selected lane's accept, stalled consumers never time out.
module painterengine_gpu_dma_reader
  import painterengine_gpu_dma_reader_pkg::*;
#(
  parameter int PARAM_DATA_ALIGN = 32,
  parameter int PARAM_TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                          i_wire_clock,
  input  logic                          i_wire_resetn,
  input  logic [3:0]                    i_wire_router,
  output logic                          o_wire_done,
  input  logic [127:0]                  i_wire_address,
  input  logic [127:0]                  i_wire_length,
  output logic [4*PARAM_DATA_ALIGN-1:0] o_wire_data,
  output logic [3:0]                    o_wire_data_valid,
  input  logic [3:0]                    i_wire_data_next,
  output logic                          o_wire_error,
  output logic [2:0]                    o_wire_error_type,
  output logic [0:0]                    o_wire_M_AXI_ARID,
  output logic [31:0]                   o_wire_M_AXI_ARADDR,
  output logic [7:0]                    o_wire_M_AXI_ARLEN,
  output logic [2:0]                    o_wire_M_AXI_ARSIZE,
  output logic [1:0]                    o_wire_M_AXI_ARBURST,
  output logic                          o_wire_M_AXI_ARLOCK,
  output logic [3:0]                    o_wire_M_AXI_ARCACHE,
  output logic [2:0]                    o_wire_M_AXI_ARPROT,
  output logic [3:0]                    o_wire_M_AXI_ARQOS,
  output logic                          o_wire_M_AXI_ARVALID,
  input  logic                          i_wire_M_AXI_ARREADY,
  input  logic [0:0]                    i_wire_M_AXI_RID,
  input  logic [PARAM_DATA_ALIGN-1:0]   i_wire_M_AXI_RDATA,
  input  logic [1:0]                    i_wire_M_AXI_RRESP,
  input  logic                          i_wire_M_AXI_RLAST,
  input  logic                          i_wire_M_AXI_RVALID,
  output logic                          o_wire_M_AXI_RREADY
);

  localparam int             TW       = $clog2(PARAM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(PARAM_TIMEOUT - 1);

  dma_state_e     state_q, state_d;
  dma_err_e       err_q, err_d;
  logic [1:0]     lane_q, lane_d;
  logic [31:0]    addr_q, addr_d, len_q, len_d, off_q, off_d, araddr_q, araddr_d;
  logic [7:0]     arlen_q, arlen_d;
  logic [8:0]     cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic [31:0]    calc_addr, next_off;
  logic [8:0]     calc_beats;
  logic           r_acc, last_beat, unused_rbits;

  painterengine_gpu_burst_calc u_burst_calc (
    .i_address    (addr_q),
    .i_offset     (off_q),
    .i_length     (len_q),
    .o_burst_addr (calc_addr),
    .o_beats      (calc_beats)
  );

  assign unused_rbits = ^{i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0]};

  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr_q;
  assign o_wire_M_AXI_ARLEN   = arlen_q;
  assign o_wire_M_AXI_ARSIZE  = AXI_SIZE_WORD;
  assign o_wire_M_AXI_ARBURST = AXI_BURST_INCR;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = AXI_CACHE_MOD;
  assign o_wire_M_AXI_ARPROT  = 3'd0;
  assign o_wire_M_AXI_ARQOS   = 4'd0;
  assign o_wire_M_AXI_ARVALID = (state_q == ST_ADDR);
  assign o_wire_done          = (state_q == ST_DONE);
  assign o_wire_error         = (state_q == ST_ERROR);
  assign o_wire_error_type    = err_q;

  always_comb begin
    o_wire_data         = '0;
    o_wire_data_valid   = '0;
    o_wire_M_AXI_RREADY = 1'b0;
    if (state_q == ST_DATA) begin
      o_wire_data_valid[lane_q]                              = i_wire_M_AXI_RVALID;
      o_wire_data[lane_q*PARAM_DATA_ALIGN +: PARAM_DATA_ALIGN] = i_wire_M_AXI_RDATA;
      o_wire_M_AXI_RREADY = i_wire_data_next[lane_q] & i_wire_M_AXI_RVALID;
    end
  end

  assign r_acc     = (state_q == ST_DATA) && i_wire_M_AXI_RVALID && i_wire_data_next[lane_q];
  assign last_beat = (cnt_q == {1'b0, arlen_q});
  assign next_off  = off_q + {24'd0, arlen_q} + 32'd1;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    lane_d   = lane_q;
    addr_d   = addr_q;
    len_d    = len_q;
    off_d    = off_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_ROUTING: begin
        case (i_wire_router)
          4'b0000: ;
          4'b0001: begin lane_d = 2'd0; state_d = ST_PARAM_CHECK; end
          4'b0010: begin lane_d = 2'd1; state_d = ST_PARAM_CHECK; end
          4'b0100: begin lane_d = 2'd2; state_d = ST_PARAM_CHECK; end
          4'b1000: begin lane_d = 2'd3; state_d = ST_PARAM_CHECK; end
          default: begin state_d = ST_ERROR; err_d = ERR_ROUTING; end
        endcase
        addr_d = i_wire_address[lane_d*32 +: 32];
        len_d  = i_wire_length[lane_d*32 +: 32];
      end
      ST_PARAM_CHECK: begin
        if (addr_q[1:0] != 2'b00) begin
          state_d = ST_ERROR; err_d = ERR_ALIGN;
        end else if (len_q == 32'd0) begin
          state_d = ST_ERROR; err_d = ERR_LENGTH;
        end else begin
          off_d = '0; state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        araddr_d = calc_addr;
        arlen_d  = 8'(calc_beats - 9'd1);
        tmo_d    = '0;
        state_d  = ST_ADDR;
      end
      ST_ADDR: begin
        if (i_wire_M_AXI_ARREADY) begin
          cnt_d = '0; tmo_d = '0; state_d = ST_DATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR; err_d = ERR_AR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_acc) begin
          tmo_d = '0;
          if (i_wire_M_AXI_RRESP[1]) begin
            state_d = ST_ERROR; err_d = ERR_RRESP;
          end else if (i_wire_M_AXI_RLAST != last_beat) begin
            state_d = ST_ERROR; err_d = ERR_RLAST;
          end else if (last_beat) begin
            off_d   = next_off;
            state_d = (next_off >= len_q) ? ST_DONE : ST_CALC;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end else if (!i_wire_M_AXI_RVALID) begin
          if (tmo_q == TMO_LAST) begin
            state_d = ST_ERROR; err_d = ERR_R_TIMEOUT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else begin
          tmo_d = '0;  // consumer stall, not a slave stall
        end
      end
      ST_DONE:  if (i_wire_router == 4'b0000) state_d = ST_ROUTING;
      ST_ERROR: ;
      default:  state_d = ST_ROUTING;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q  <= ST_ROUTING;
      err_q    <= ERR_NONE;
      lane_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      off_q    <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      off_q    <= off_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Directed bench: behavioural AXI read slave plus lane consumer around the DMA reader.
module tb_painterengine_gpu_dma_reader;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   router;
  logic         done;
  logic [127:0] address, length, data_out;
  logic [3:0]   data_valid, data_next;
  logic         error;
  logic [2:0]   error_type;
  logic [0:0]   arid, rid;
  logic [31:0]  araddr, rdata;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, rresp;
  logic         arlock, arvalid, arready, rlast, rvalid, rready;
  logic [3:0]   arcache, arqos;

  always #5 clk = ~clk;

  painterengine_gpu_dma_reader dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_router(router), .o_wire_done(done),
    .i_wire_address(address), .i_wire_length(length), .o_wire_data(data_out),
    .o_wire_data_valid(data_valid), .i_wire_data_next(data_next), .o_wire_error(error),
    .o_wire_error_type(error_type), .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr),
    .o_wire_M_AXI_ARLEN(arlen), .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst),
    .o_wire_M_AXI_ARLOCK(arlock), .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot),
    .o_wire_M_AXI_ARQOS(arqos), .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Slave / consumer controls and observations
  bit          ar_ready_en = 1'b1, r_en = 1'b1, next_toggle = 1'b0;
  int          err_beat = -1, early_last = -1;
  int          beat_total = 0, cur_beat = 0, cyc = 0;
  bit          ar_seen = 1'b0;
  int          rready_bad = 0, other_nz = 0;
  logic [1:0]  mon_lane = 2'd0;
  logic [31:0] q_addr[$];
  logic [7:0]  q_len[$];
  logic [31:0] ar_log_addr[$], words[$];
  logic [7:0]  ar_log_len[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Observe at the falling edge, drive just after the rising edge.
  initial begin
    bit            ar_hs, r_hs;
    logic [127:0]  mask;
    arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    data_next = 4'hF;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (arvalid) ar_seen = 1'b1;
      if (ar_hs) begin
        ar_log_addr.push_back(araddr); ar_log_len.push_back(arlen);
        q_addr.push_back(araddr);      q_len.push_back(arlen);
      end
      if (data_valid[mon_lane] && (rready !== data_next[mon_lane])) rready_bad++;
      if (data_valid[mon_lane] && data_next[mon_lane]) words.push_back(data_out[mon_lane*32 +: 32]);
      mask = 128'(32'hFFFF_FFFF) << (mon_lane * 32);
      if ((data_out & ~mask) != '0) other_nz++;
      @(posedge clk);
      #1;
      cyc++;
      data_next = (next_toggle && cyc[0]) ? 4'h0 : 4'hF;
      if (!resetn) begin
        q_addr.delete(); q_len.delete(); cur_beat = 0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
      end else begin
        if (r_hs) begin
          cur_beat++; beat_total++;
          if (cur_beat > int'(q_len[0])) begin
            void'(q_addr.pop_front()); void'(q_len.pop_front()); cur_beat = 0;
          end
        end
        if (q_len.size() != 0 && r_en) begin
          rvalid = 1'b1;
          rdata  = q_addr[0] + 32'(cur_beat * 4);
          rlast  = (cur_beat == int'(q_len[0])) || (cur_beat == early_last);
          rresp  = (beat_total == err_beat) ? 2'd2 : 2'd0;
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        end
      end
      arready = ar_ready_en;
    end
  end

  task automatic do_reset();
    router = 4'd0;
    resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    step();
  endtask

  task automatic start(input int lane, input logic [31:0] a, input logic [31:0] l);
    address = '0; length = '0;
    address[lane*32 +: 32] = a;
    length[lane*32 +: 32]  = l;
    mon_lane = 2'(lane);
    words.delete(); ar_log_addr.delete(); ar_log_len.delete();
    ar_seen = 1'b0; rready_bad = 0; other_nz = 0; beat_total = 0;
    router = 4'b0001 << lane;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic release_router();
    router = 4'd0;
    step(); step();
  endtask

  initial begin
    bit ok;
    resetn = 1'b0; router = '0; address = '0; length = '0;
    step();
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_data_or", 32'(|data_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", {28'd0, error, error_type}, 0);
    do_reset();

    // Single short burst on lane 2
    start(2, 32'h1000_0000, 32'd4);
    wait_end(200, ok);
    chk("t1_end", 32'(ok), 1);
    chk("t1_done", 32'(done), 1);
    chk("t1_error", 32'(error), 0);
    chk("t1_nbursts", 32'(ar_log_addr.size()), 1);
    chk("t1_araddr", ar_log_addr[0], 32'h1000_0000);
    chk("t1_arlen", 32'(ar_log_len[0]), 3);
    chk("t1_nwords", 32'(words.size()), 4);
    for (int k = 0; k < 4; k++) chk("t1_word", words[k], 32'h1000_0000 + 32'(k * 4));
    chk("t1_other_lanes", 32'(other_nz), 0);
    release_router();
    chk("t1_done_clear", 32'(done), 0);

    // Boundary splitting: 300 words from 0x3F8
    start(0, 32'h0000_03F8, 32'd300);
    wait_end(1500, ok);
    chk("t2_end", 32'(ok), 1);
    chk("t2_done", 32'(done), 1);
    chk("t2_nbursts", 32'(ar_log_addr.size()), 3);
    chk("t2_addr0", ar_log_addr[0], 32'h0000_03F8);
    chk("t2_len0", 32'(ar_log_len[0]), 1);
    chk("t2_addr1", ar_log_addr[1], 32'h0000_0400);
    chk("t2_len1", 32'(ar_log_len[1]), 255);
    chk("t2_addr2", ar_log_addr[2], 32'h0000_0800);
    chk("t2_len2", 32'(ar_log_len[2]), 41);
    chk("t2_nwords", 32'(words.size()), 300);
    for (int k = 0; k < 300; k++) chk("t2_word", words[k], 32'h0000_03F8 + 32'(k * 4));
    release_router();

    // Parameter errors never touch the AR channel
    start(0, 32'h0000_1000, 32'd4);
    router = 4'b0011;
    wait_end(50, ok);
    chk("t3_route_type", 32'(error_type), 1);
    chk("t3_route_err", 32'(error), 1);
    chk("t3_route_ar", 32'(ar_seen), 0);
    do_reset();
    start(0, 32'h0000_0002, 32'd4);
    wait_end(50, ok);
    chk("t3_align_type", 32'(error_type), 2);
    chk("t3_align_ar", 32'(ar_seen), 0);
    do_reset();
    start(1, 32'h0000_1000, 32'd0);
    wait_end(50, ok);
    chk("t3_len_type", 32'(error_type), 3);
    chk("t3_len_ar", 32'(ar_seen), 0);
    do_reset();

    // Consumer accepting every other cycle
    next_toggle = 1'b1;
    start(3, 32'h2000_0000, 32'd16);
    wait_end(300, ok);
    next_toggle = 1'b0;
    chk("t4_done", 32'(done), 1);
    chk("t4_error", 32'(error), 0);
    chk("t4_rready_follow", 32'(rready_bad), 0);
    chk("t4_nwords", 32'(words.size()), 16);
    for (int k = 0; k < 16; k++) chk("t4_word", words[k], 32'h2000_0000 + 32'(k * 4));
    release_router();

    // SLVERR on the fifth beat
    err_beat = 4;
    start(1, 32'h0000_0100, 32'd8);
    wait_end(200, ok);
    chk("t5_type", 32'(error_type), 5);
    chk("t5_nwords", 32'(words.size()), 5);
    step(); step();
    chk("t5_rready_low", 32'(rready), 0);
    chk("t5_valid_low", 32'(data_valid), 0);
    chk("t5_sticky", 32'(error), 1);
    err_beat = -1;
    do_reset();

    // RLAST on beat 3 of a 4-beat burst
    early_last = 2;
    start(0, 32'h0000_0200, 32'd4);
    wait_end(200, ok);
    chk("t6_type", 32'(error_type), 6);
    chk("t6_nwords", 32'(words.size()), 3);
    early_last = -1;
    do_reset();

    // AR and R timeouts
    ar_ready_en = 1'b0;
    start(0, 32'h0000_0300, 32'd4);
    wait_end(400, ok);
    chk("t7_ar_tmo_type", 32'(error_type), 4);
    chk("t7_ar_none", 32'(ar_log_addr.size()), 0);
    ar_ready_en = 1'b1;
    do_reset();
    r_en = 1'b0;
    start(0, 32'h0000_0300, 32'd4);
    wait_end(400, ok);
    chk("t7_r_tmo_type", 32'(error_type), 7);
    chk("t7_r_one_ar", 32'(ar_log_addr.size()), 1);
    r_en = 1'b1;
    do_reset();

    // Reset in the middle of a burst, then a fresh lane-1 request
    next_toggle = 1'b1;
    start(2, 32'h0000_3000, 32'd64);
    repeat (12) step();
    chk("t8_in_data", 32'(words.size() > 0), 1);
    resetn = 1'b0;
    router = 4'd0;
    step();
    chk("t8_arvalid", 32'(arvalid), 0);
    chk("t8_rready", 32'(rready), 0);
    chk("t8_valid", 32'(data_valid), 0);
    chk("t8_data_or", 32'(|data_out), 0);
    chk("t8_flags", {28'd0, done, error, error_type[1:0]} | {31'd0, error_type[2]}, 0);
    step(); step();
    resetn = 1'b1;
    next_toggle = 1'b0;
    step();
    start(1, 32'h0000_4000, 32'd5);
    wait_end(200, ok);
    chk("t8_done", 32'(done), 1);
    chk("t8_error", 32'(error), 0);
    chk("t8_nwords", 32'(words.size()), 5);
    for (int k = 0; k < 5; k++) chk("t8_word", words[k], 32'h0000_4000 + 32'(k * 4));
    release_router();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
